// File: rtl/issue_scoreboard_if.sv
// Fetch-to-decode issue channel: the fetched instruction goes in, and the
// decode-side IR, stall and statistics come back out.
interface issue_scoreboard_if;
    logic [31:0] ir_in;
    logic        ir_valid;
    logic        flush;
    logic        stall;
    logic [31:0] ir_out;
    logic        bubble;
    logic [15:0] stall_cycles;

    modport master (
        output ir_in, ir_valid, flush,
        input  stall, ir_out, bubble, stall_cycles
    );

    modport slave (
        input  ir_in, ir_valid, flush,
        output stall, ir_out, bubble, stall_cycles
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue stage with per-register writeback countdowns: stalls fetch only on a
// real RAW hazard and squashes wrong-path issue when a branch is taken.
module issue_scoreboard #(
    parameter int unsigned WB_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    issue_scoreboard_if.slave bus
);
    localparam logic [31:0] BUBBLE_IR = 32'hFFFF_FFFF;
    localparam logic [2:0]  LAT       = 3'(WB_LAT);
    localparam bit          AGE1_LIVE = (WB_LAT > 1);
    localparam bit          AGE2_LIVE = (WB_LAT > 2);
    localparam logic [2:0]  AGE1_CNT  = AGE1_LIVE ? 3'(WB_LAT - 1) : 3'd0;
    localparam logic [2:0]  AGE2_CNT  = AGE2_LIVE ? 3'(WB_LAT - 2) : 3'd0;

    logic [2:0]  cnt_reg  [32];
    logic [2:0]  cnt_next [32];
    logic [4:0]  h1_dest_reg, h2_dest_reg;
    logic        h1_valid_reg, h2_valid_reg;
    logic [31:0] ir_out_reg;
    logic        bubble_reg;
    logic [15:0] stall_cycles_reg;

    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       in_bubble;
    logic       reads_rs, reads_rt, writes;
    logic [4:0] dest;
    logic       hazard, issue, wr_en;

    assign op = bus.ir_in[31:26];
    assign rs = bus.ir_in[25:21];
    assign rt = bus.ir_in[20:16];
    assign rd = bus.ir_in[15:11];
    assign in_bubble = !bus.ir_valid || (bus.ir_in == BUBBLE_IR);

    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        writes   = 1'b0;
        dest     = 5'd0;
        if (!in_bubble) begin
            if (op == 6'h00) begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                writes   = 1'b1;
                dest     = rd;
            end else if (op == 6'h23 || op[5:3] == 3'b001) begin
                reads_rs = 1'b1;
                writes   = 1'b1;
                dest     = rt;
            end else if (op == 6'h2B || op == 6'h04 || op == 6'h05) begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
        end
    end

    assign hazard = (reads_rs && rs != 5'd0 && cnt_reg[rs] != 3'd0) ||
                    (reads_rt && rt != 5'd0 && cnt_reg[rt] != 3'd0);
    assign issue  = !in_bubble && !hazard && !bus.flush;
    assign wr_en  = issue && writes && (dest != 5'd0);

    assign cnt_next[0] = 3'd0;

    // Age counts the flush edge itself, so a writer issued one edge ago is
    // recognised by its decremented count being WB_LAT-1 (and WB_LAT-2 for two).
    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
        logic [2:0] dec;
        logic       clr;
        assign dec = (cnt_reg[gi] == 3'd0) ? 3'd0 : cnt_reg[gi] - 3'd1;
        assign clr = bus.flush &&
                     ((AGE1_LIVE && h1_valid_reg && h1_dest_reg == 5'(gi) && dec == AGE1_CNT) ||
                      (AGE2_LIVE && h2_valid_reg && h2_dest_reg == 5'(gi) && dec == AGE2_CNT));
        assign cnt_next[gi] = clr ? 3'd0 :
                              (wr_en && dest == 5'(gi)) ? LAT : dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_reg[i] <= 3'd0;
            end
            h1_dest_reg      <= 5'd0;
            h2_dest_reg      <= 5'd0;
            h1_valid_reg     <= 1'b0;
            h2_valid_reg     <= 1'b0;
            ir_out_reg       <= BUBBLE_IR;
            bubble_reg       <= 1'b1;
            stall_cycles_reg <= 16'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            h2_dest_reg  <= h1_dest_reg;
            h2_valid_reg <= h1_valid_reg;
            h1_dest_reg  <= dest;
            if (bus.flush) begin
                ir_out_reg   <= BUBBLE_IR;
                bubble_reg   <= 1'b1;
                h1_valid_reg <= 1'b0;
                h2_valid_reg <= 1'b0;
            end else if (hazard) begin
                ir_out_reg   <= BUBBLE_IR;
                bubble_reg   <= 1'b1;
                h1_valid_reg <= 1'b0;
                if (stall_cycles_reg != 16'hFFFF) begin
                    stall_cycles_reg <= stall_cycles_reg + 16'd1;
                end
            end else if (issue) begin
                ir_out_reg   <= bus.ir_in;
                bubble_reg   <= 1'b0;
                h1_valid_reg <= wr_en;
            end else begin
                ir_out_reg   <= BUBBLE_IR;
                bubble_reg   <= 1'b1;
                h1_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.stall        = hazard && !bus.flush && !rst;
    assign bus.ir_out       = ir_out_reg;
    assign bus.bubble       = bubble_reg;
    assign bus.stall_cycles = stall_cycles_reg;
endmodule
